// File: rtl/bullet_ctrl.sv
// bullet_ctrl: bullet slot manager for a VGA tank game.
//
// Once per video frame (rising edge of vs) the controller optionally spawns
// a bullet from the tank, then walks every slot once, advancing position,
// ageing it and retiring it on expiry or when it reaches the screen edge.
// A registered pixel test reports whether the current VGA pixel lies inside
// any live bullet sprite.
//
// Optional feature macro: BULLET_WALL_BOUNCE_EN
//   undefined (default): a bullet that goes out of bounds dies.
//   defined            : a bullet bounces off the wall instead (velocity
//                        component negated, coordinate restored).
//
// Handshake/timing note: there is no valid/ready traffic here. vs is an
// asynchronous level that is synchronised; fire is a level whose rising
// edge latches a one-frame request; all outputs are registered.
// fsm_state is a debug view of the frame-update FSM
// (0 IDLE, 1 SPAWN, 2 MOVE, 3 DONE).

module bullet_ctrl #(
    parameter int NUM_BULLETS = 4,
    parameter int LIFETIME    = 240,
    parameter int COOLDOWN    = 15,
    parameter int BULLET_R    = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   vs,
    input  logic                   fire,
    input  logic [9:0]             tank_x,
    input  logic [9:0]             tank_y,
    input  logic [7:0]             sin,
    input  logic [7:0]             cos,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    output logic                   bullet_on,
    output logic [NUM_BULLETS-1:0] active_mask,
    output logic [1:0]             fsm_state
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS - 1);

    // Screen limits on the integer part of a coordinate
    localparam logic [9:0] LO_LIM = 10'(BULLET_R);
    localparam logic [9:0] X_HI   = 10'(639 - BULLET_R);
    localparam logic [9:0] Y_HI   = 10'(479 - BULLET_R);

    localparam logic signed [10:0] R_S = 11'(BULLET_R);
    localparam logic [7:0] LIFE_INIT = 8'(LIFETIME);
    localparam logic [7:0] CD_INIT   = 8'(COOLDOWN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPAWN = 2'd1,
        S_MOVE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             vs_s1_q, vs_s2_q, vs_prev_q;
    logic             fire_prev_q;
    logic             pending_q;
    logic             req_q;
    logic [7:0]       cd_q;
    logic [IDX_W-1:0] idx_q;

    logic [NUM_BULLETS-1:0] alive_q;
    logic [15:0]            px_q   [NUM_BULLETS];
    logic [15:0]            py_q   [NUM_BULLETS];
    logic [15:0]            vx_q   [NUM_BULLETS];
    logic [15:0]            vy_q   [NUM_BULLETS];
    logic [7:0]             life_q [NUM_BULLETS];

    logic                   bullet_on_q;
    logic [NUM_BULLETS-1:0] mask_q;

    logic             tick_d;
    logic             fire_rise_d;
    logic             free_found_d;
    logic [IDX_W-1:0] free_idx_d;
    logic [15:0]      mv_px_d, mv_py_d;
    logic [7:0]       mv_life_d;
    logic             mv_oob_x_d, mv_oob_y_d;
    logic             hit_d;
    logic signed [10:0] dx_d, dy_d;

    // Frame tick and fire edge detection
    always_comb begin
        tick_d      = vs_s2_q & ~vs_prev_q;
        fire_rise_d = fire & ~fire_prev_q;
    end

    // Lowest-index free slot for spawning
    always_comb begin
        free_found_d = 1'b0;
        free_idx_d   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!alive_q[i]) begin
                free_found_d = 1'b1;
                free_idx_d   = IDX_W'(i);
            end
        end
    end

    // Candidate update for the slot being visited in MOVE
    always_comb begin
        mv_px_d    = px_q[idx_q] + vx_q[idx_q];
        mv_py_d    = py_q[idx_q] + vy_q[idx_q];
        mv_life_d  = life_q[idx_q] - 8'd1;
        mv_oob_x_d = (mv_px_d[15:6] <= LO_LIM) || (mv_px_d[15:6] >= X_HI);
        mv_oob_y_d = (mv_py_d[15:6] <= LO_LIM) || (mv_py_d[15:6] >= Y_HI);
    end

    // Pixel-inside-sprite test against every live slot (11-bit signed deltas)
    always_comb begin
        hit_d = 1'b0;
        dx_d  = '0;
        dy_d  = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            dx_d = $signed({1'b0, DrawX}) - $signed({1'b0, px_q[i][15:6]});
            dy_d = $signed({1'b0, DrawY}) - $signed({1'b0, py_q[i][15:6]});
            if (alive_q[i] && (dx_d >= -R_S) && (dx_d <= R_S) &&
                (dy_d >= -R_S) && (dy_d <= R_S)) begin
                hit_d = 1'b1;
            end
        end
    end

    // Frame-update FSM, slot state, synchronisers and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            vs_prev_q   <= 1'b0;
            fire_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            req_q       <= 1'b0;
            cd_q        <= '0;
            idx_q       <= '0;
            alive_q     <= '0;
            bullet_on_q <= 1'b0;
            mask_q      <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                px_q[i]   <= '0;
                py_q[i]   <= '0;
                vx_q[i]   <= '0;
                vy_q[i]   <= '0;
                life_q[i] <= '0;
            end
        end else begin
            vs_s1_q     <= vs;
            vs_s2_q     <= vs_s1_q;
            vs_prev_q   <= vs_s2_q;
            fire_prev_q <= fire;
            bullet_on_q <= hit_d;
            mask_q      <= alive_q;

            // A request lives for exactly one frame: the tick consumes it.
            if (tick_d) begin
                pending_q <= 1'b0;
            end else if (fire_rise_d) begin
                pending_q <= 1'b1;
            end

            if (tick_d && (cd_q != 8'd0)) begin
                cd_q <= cd_q - 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    // Ticks outside IDLE are simply ignored.
                    if (tick_d) begin
                        req_q   <= pending_q;
                        idx_q   <= '0;
                        state_q <= S_SPAWN;
                    end
                end

                S_SPAWN: begin
                    if (req_q && (cd_q == 8'd0) && free_found_d) begin
                        alive_q[free_idx_d] <= 1'b1;
                        px_q[free_idx_d]    <= {tank_x, 6'b0};
                        py_q[free_idx_d]    <= {tank_y, 6'b0};
                        vx_q[free_idx_d]    <= {{8{cos[7]}}, cos};
                        vy_q[free_idx_d]    <= 16'd0 - {{8{sin[7]}}, sin};
                        life_q[free_idx_d]  <= LIFE_INIT;
                        cd_q                <= CD_INIT;
                    end
                    req_q   <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_MOVE;
                end

                S_MOVE: begin
                    if (alive_q[idx_q]) begin
                        life_q[idx_q] <= mv_life_d;
`ifdef BULLET_WALL_BOUNCE_EN
                        // Bounce: reflect the offending axis, keep old coordinate
                        if (mv_oob_x_d) begin
                            vx_q[idx_q] <= 16'd0 - vx_q[idx_q];
                        end else begin
                            px_q[idx_q] <= mv_px_d;
                        end
                        if (mv_oob_y_d) begin
                            vy_q[idx_q] <= 16'd0 - vy_q[idx_q];
                        end else begin
                            py_q[idx_q] <= mv_py_d;
                        end
                        if (mv_life_d == 8'd0) begin
                            alive_q[idx_q] <= 1'b0;
                        end
`else
                        px_q[idx_q] <= mv_px_d;
                        py_q[idx_q] <= mv_py_d;
                        if ((mv_life_d == 8'd0) || mv_oob_x_d || mv_oob_y_d) begin
                            alive_q[idx_q] <= 1'b0;
                        end
`endif
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive
    always_comb begin
        bullet_on   = bullet_on_q;
        active_mask = mask_q;
        fsm_state   = state_q;
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: randomized and directed checks of bullet_ctrl against a
// frame-level behavioural model (one model step per video frame).

module tb_bullet_ctrl;

    localparam int NB   = 4;
    localparam int LIFE = 240;
    localparam int CDN  = 15;
    localparam int R    = 2;

    // Clock / reset block
    logic          CLK   = 1'b0;
    logic          RESET = 1'b1;
    logic          vs    = 1'b0;
    logic          fire  = 1'b0;
    logic [9:0]    tank_x = '0;
    logic [9:0]    tank_y = '0;
    logic [7:0]    sin   = '0;
    logic [7:0]    cos   = '0;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic          bullet_on;
    logic [NB-1:0] active_mask;
    logic [1:0]    fsm_state;

    int n_total = 0;
    int n_bad   = 0;

    always #10 CLK = ~CLK;

    bullet_ctrl #(
        .NUM_BULLETS(NB),
        .LIFETIME   (LIFE),
        .COOLDOWN   (CDN),
        .BULLET_R   (R)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .vs         (vs),
        .fire       (fire),
        .tank_x     (tank_x),
        .tank_y     (tank_y),
        .sin        (sin),
        .cos        (cos),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .bullet_on  (bullet_on),
        .active_mask(active_mask),
        .fsm_state  (fsm_state)
    );

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1, "watchdog");
    end

    // Frame-level reference model
    bit m_alive [NB];
    int m_x     [NB];
    int m_y     [NB];
    int m_vx    [NB];
    int m_vy    [NB];
    int m_life  [NB];
    bit m_pending;
    int m_cd;

    // Scoreboard expected queue for pixel scans
    logic [0:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h required=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_alive[i] = 1'b0;
            m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
        end
        m_pending = 1'b0;
        m_cd = 0;
    endtask

    // One frame of game rules: consume request, cool down, spawn, move all
    task automatic model_tick();
        bit pend;
        int slot;
        int nx, ny, ix, iy;
        bit ox, oy;
        pend = m_pending;
        m_pending = 1'b0;
        if (m_cd > 0) m_cd--;
        if (pend && m_cd == 0) begin
            slot = -1;
            for (int i = NB - 1; i >= 0; i--) if (!m_alive[i]) slot = i;
            if (slot >= 0) begin
                m_alive[slot] = 1'b1;
                m_x[slot]     = int'(tank_x) * 64;
                m_y[slot]     = int'(tank_y) * 64;
                m_vx[slot]    = int'($signed(cos));
                m_vy[slot]    = -int'($signed(sin));
                m_life[slot]  = LIFE;
                m_cd          = CDN;
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (m_alive[i]) begin
                nx = (m_x[i] + m_vx[i]) & 'hFFFF;
                ny = (m_y[i] + m_vy[i]) & 'hFFFF;
                m_life[i] = m_life[i] - 1;
                ix = nx / 64;
                iy = ny / 64;
                ox = (ix <= R) || (ix >= 639 - R);
                oy = (iy <= R) || (iy >= 479 - R);
`ifdef BULLET_WALL_BOUNCE_EN
                if (ox) m_vx[i] = -m_vx[i]; else m_x[i] = nx;
                if (oy) m_vy[i] = -m_vy[i]; else m_y[i] = ny;
                if (m_life[i] == 0) m_alive[i] = 1'b0;
`else
                m_x[i] = nx;
                m_y[i] = ny;
                if (m_life[i] == 0 || ox || oy) m_alive[i] = 1'b0;
`endif
            end
        end
    endtask

    function automatic logic [NB-1:0] model_mask();
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[i] = m_alive[i];
        return m;
    endfunction

    function automatic logic expected_on(input int x, input int y);
        int bx, by, ddx, ddy;
        for (int i = 0; i < NB; i++) begin
            if (m_alive[i]) begin
                bx  = m_x[i] / 64;
                by  = m_y[i] / 64;
                ddx = (x > bx) ? x - bx : bx - x;
                ddy = (y > by) ? y - by : by - y;
                if (ddx <= R && ddy <= R) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Driver tasks
    task automatic apply_reset();
        vs   = 1'b0;
        fire = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_eq("reset_mask", active_mask, '0);
        check_eq("reset_on", bullet_on, 1'b0);
        check_eq("reset_state", fsm_state, 2'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
    endtask

    task automatic set_fire(input logic v);
        if (v && !fire) m_pending = 1'b1;
        fire = v;
        @(negedge CLK);
    endtask

    task automatic fire_pulse();
        set_fire(1'b1);
        set_fire(1'b0);
    endtask

    task automatic set_dir(input int c, input int s);
        cos = 8'(c);
        sin = 8'(s);
    endtask

    task automatic run_frame();
        vs = 1'b1;
        repeat (6) @(negedge CLK);
        vs = 1'b0;
        repeat (14) @(negedge CLK);
        model_tick();
        check_eq("active_mask", active_mask, model_mask());
        check_eq("fsm_idle", fsm_state, 2'd0);
    endtask

    task automatic probe(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge CLK);
        check_eq("bullet_on", bullet_on, expected_on(x, y));
    endtask

    task automatic probe_slots();
        for (int i = 0; i < NB; i++) begin
            if (m_alive[i]) begin
                probe(m_x[i] / 64, m_y[i] / 64);
                probe(m_x[i] / 64 + $urandom_range(0, 2 * R + 4) - (R + 2),
                      m_y[i] / 64 + $urandom_range(0, 2 * R + 4) - (R + 2));
            end
        end
        probe($urandom_range(0, 639), $urandom_range(0, 479));
    endtask

    initial begin
        int guard;
        logic [0:0] e;

        model_reset();
        apply_reset();

        // Single shot moving right from the centre
        tank_x = 10'd320; tank_y = 10'd240; set_dir(127, 0);
        fire_pulse();
        run_frame();
        check_eq("first_spawn_mask", active_mask, 4'b0001);
        probe(321, 240);
        probe(321 + R + 1, 240);
        probe(321 - R, 240);
        for (int f = 0; f < 10; f++) begin
            run_frame();
            probe_slots();
        end

        // Fire held for 100 frames: one spawn only
        apply_reset();
        tank_x = 10'd100; tank_y = 10'd240; set_dir(127, 0);
        set_fire(1'b1);
        for (int f = 0; f < 100; f++) run_frame();
        check_eq("held_fire_mask", active_mask, 4'b0001);
        set_fire(1'b0);

        // Five pulses one frame apart: cooldown blocks all but the first
        apply_reset();
        tank_x = 10'd320; tank_y = 10'd240; set_dir(20, 10);
        for (int f = 0; f < 5; f++) begin
            fire_pulse();
            run_frame();
        end
        check_eq("cooldown_mask", active_mask, 4'b0001);

        // Fill all slots, discard fifth, reuse slot0 after expiry
        apply_reset();
        tank_x = 10'd320; tank_y = 10'd240; set_dir(10, 5);
        for (int f = 0; f <= 242; f++) begin
            if (f == 0 || f == 16 || f == 32 || f == 48 || f == 64 || f == 240) fire_pulse();
            run_frame();
            if (f == 64) check_eq("fifth_discard", active_mask, 4'b1111);
            if (f == 239) check_eq("slot0_expired", active_mask, 4'b1110);
            if (f == 240) check_eq("slot0_reuse", active_mask, 4'b1111);
            if (f % 40 == 0) probe_slots();
        end

        // Spawn close to the right wall
        apply_reset();
        tank_x = 10'd630; tank_y = 10'd240; set_dir(127, 0);
        fire_pulse();
        for (int f = 0; f < 6; f++) begin
            run_frame();
            probe_slots();
        end
`ifdef BULLET_WALL_BOUNCE_EN
        check_eq("wall_bounce_alive", active_mask, 4'b0001);
`else
        check_eq("wall_kill", active_mask, 4'b0000);
`endif

        // Stationary bullet at (100,50), scan one line around it
        apply_reset();
        tank_x = 10'd100; tank_y = 10'd50; set_dir(0, 0);
        fire_pulse();
        run_frame();
        DrawY = 10'd50;
        DrawX = 10'd96;
        @(negedge CLK);
        exp_q.push_back(1'b0);
        for (int x = 97; x <= 104; x++) begin
            DrawX = 10'(x);
            #1;
            check_eq("scan_latency", bullet_on, exp_q[$]);
            exp_q.push_back((x >= 98 && x <= 102) ? 1'b1 : 1'b0);
            @(negedge CLK);
            e = exp_q[$];
            check_eq("scan_on", bullet_on, e);
            void'(exp_q.pop_front());
        end
        exp_q.delete();

        // Randomized frames
        apply_reset();
        for (int f = 0; f < 150; f++) begin
            tank_x = 10'($urandom_range(20, 619));
            tank_y = 10'($urandom_range(20, 459));
            set_dir(int'($urandom_range(0, 254)) - 127, int'($urandom_range(0, 254)) - 127);
            if ($urandom_range(0, 3) == 0) fire_pulse();
            run_frame();
            probe_slots();
        end

        // Reset in the middle of MOVE
        apply_reset();
        tank_x = 10'd200; tank_y = 10'd200; set_dir(127, 0);
        fire_pulse();
        vs = 1'b1;
        guard = 0;
        while (fsm_state != 2'd2 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        check_eq("reach_move", fsm_state, 2'd2);
        @(negedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        check_eq("midreset_mask", active_mask, '0);
        check_eq("midreset_on", bullet_on, 1'b0);
        check_eq("midreset_state", fsm_state, 2'd0);
        vs = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        for (int f = 0; f < 3; f++) run_frame();
        check_eq("no_spawn_after_reset", active_mask, 4'b0000);
        fire_pulse();
        run_frame();
        check_eq("spawn_after_reset", active_mask, 4'b0001);

        // Final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
